memory_block_wrapper: RTL and testbench



---
 rtl/memory_block_wrapper.sv | 158 +++++++++++++++
 tb/tb_memory_block_wrapper.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_block_wrapper.sv
// Shared word-addressed scratch memory behind two independent single-beat AXI4 slave ports.
// Define MEM_BLOCK_ZERO_INIT_EN to start the array at all zeros; otherwise contents start undefined.
module memory_block_wrapper #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  sys_clock,
    input  logic                  reset_rtl,

    input  logic [ADDR_WIDTH-1:0] S_AXI_0_awaddr,
    input  logic                  S_AXI_0_awvalid,
    output logic                  S_AXI_0_awready,
    input  logic [DATA_WIDTH-1:0] S_AXI_0_wdata,
    input  logic                  S_AXI_0_wvalid,
    output logic                  S_AXI_0_wready,
    output logic                  S_AXI_0_bvalid,
    input  logic                  S_AXI_0_bready,
    input  logic [ADDR_WIDTH-1:0] S_AXI_0_araddr,
    input  logic                  S_AXI_0_arvalid,
    output logic                  S_AXI_0_arready,
    output logic [DATA_WIDTH-1:0] S_AXI_0_rdata,
    output logic                  S_AXI_0_rvalid,
    input  logic                  S_AXI_0_rready,

    input  logic [ADDR_WIDTH-1:0] S_AXI_1_awaddr,
    input  logic                  S_AXI_1_awvalid,
    output logic                  S_AXI_1_awready,
    input  logic [DATA_WIDTH-1:0] S_AXI_1_wdata,
    input  logic                  S_AXI_1_wvalid,
    output logic                  S_AXI_1_wready,
    output logic                  S_AXI_1_bvalid,
    input  logic                  S_AXI_1_bready,
    input  logic [ADDR_WIDTH-1:0] S_AXI_1_araddr,
    input  logic                  S_AXI_1_arvalid,
    output logic                  S_AXI_1_arready,
    output logic [DATA_WIDTH-1:0] S_AXI_1_rdata,
    output logic                  S_AXI_1_rvalid,
    input  logic                  S_AXI_1_rready
);

    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam int DEPTH = 1 << IDX_W;

`ifdef MEM_BLOCK_ZERO_INIT_EN
    logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};
`else
    logic [DATA_WIDTH-1:0] mem [DEPTH];
`endif

    // Handshakes: a transfer happens on an edge where valid && ready; the source holds
    // valid and payload stable until then, and the slave's ready never depends on valid.

    // Byte lanes within a word are not addressable.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{S_AXI_0_awaddr[1:0], S_AXI_0_araddr[1:0],
                                S_AXI_1_awaddr[1:0], S_AXI_1_araddr[1:0]};

    logic [1:0]            awvalid_v, wvalid_v, bready_v, arvalid_v, rready_v;
    logic [IDX_W-1:0]      awidx_v [2];
    logic [IDX_W-1:0]      aridx_v [2];
    logic [DATA_WIDTH-1:0] wdata_v [2];

    assign awvalid_v  = {S_AXI_1_awvalid, S_AXI_0_awvalid};
    assign wvalid_v   = {S_AXI_1_wvalid,  S_AXI_0_wvalid};
    assign bready_v   = {S_AXI_1_bready,  S_AXI_0_bready};
    assign arvalid_v  = {S_AXI_1_arvalid, S_AXI_0_arvalid};
    assign rready_v   = {S_AXI_1_rready,  S_AXI_0_rready};
    assign awidx_v[0] = S_AXI_0_awaddr[ADDR_WIDTH-1:2];
    assign awidx_v[1] = S_AXI_1_awaddr[ADDR_WIDTH-1:2];
    assign aridx_v[0] = S_AXI_0_araddr[ADDR_WIDTH-1:2];
    assign aridx_v[1] = S_AXI_1_araddr[ADDR_WIDTH-1:2];
    assign wdata_v[0] = S_AXI_0_wdata;
    assign wdata_v[1] = S_AXI_1_wdata;

    // Keeps every ready low until the first edge after reset is released.
    logic ready_en;
    always_ff @(posedge sys_clock) begin
        if (reset_rtl) ready_en <= 1'b0;
        else           ready_en <= 1'b1;
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic                  aw_full, w_full, bvalid, rvalid;
        logic [IDX_W-1:0]      aw_idx;
        logic [DATA_WIDTH-1:0] w_data, rdata;
        logic                  awready, wready, arready;
        logic                  aw_hs, w_hs, ar_hs, commit;
        logic [IDX_W-1:0]      commit_idx;
        logic [DATA_WIDTH-1:0] commit_data;

        assign awready = ready_en && !aw_full && !bvalid;
        assign wready  = ready_en && !w_full && !bvalid;
        assign arready = ready_en && !rvalid;
        assign aw_hs   = awvalid_v[p] && awready;
        assign w_hs    = wvalid_v[p] && wready;
        assign ar_hs   = arvalid_v[p] && arready;

        // Commit as soon as address and data are both on hand, held or arriving now.
        assign commit      = !reset_rtl && (aw_full || aw_hs) && (w_full || w_hs);
        assign commit_idx  = aw_full ? aw_idx : awidx_v[p];
        assign commit_data = w_full ? w_data : wdata_v[p];

        always_ff @(posedge sys_clock) begin
            if (reset_rtl) begin
                aw_full <= 1'b0;
                w_full  <= 1'b0;
                bvalid  <= 1'b0;
            end else if (commit) begin
                aw_full <= 1'b0;
                w_full  <= 1'b0;
                bvalid  <= 1'b1;
            end else begin
                if (aw_hs) begin
                    aw_full <= 1'b1;
                    aw_idx  <= awidx_v[p];
                end
                if (w_hs) begin
                    w_full <= 1'b1;
                    w_data <= wdata_v[p];
                end
                if (bvalid && bready_v[p]) bvalid <= 1'b0;
            end
        end

        // Non-blocking read of mem gives read-first behaviour against same-edge writes.
        always_ff @(posedge sys_clock) begin
            if (reset_rtl) begin
                rvalid <= 1'b0;
                rdata  <= '0;
            end else if (ar_hs) begin
                rvalid <= 1'b1;
                rdata  <= mem[aridx_v[p]];
            end else if (rready_v[p]) begin
                rvalid <= 1'b0;
            end
        end
    end

    // Port 0 is applied last so it wins a same-word, same-edge collision.
    always_ff @(posedge sys_clock) begin
        if (g_port[1].commit) mem[g_port[1].commit_idx] <= g_port[1].commit_data;
        if (g_port[0].commit) mem[g_port[0].commit_idx] <= g_port[0].commit_data;
    end

    assign S_AXI_0_awready = g_port[0].awready;
    assign S_AXI_0_wready  = g_port[0].wready;
    assign S_AXI_0_bvalid  = g_port[0].bvalid;
    assign S_AXI_0_arready = g_port[0].arready;
    assign S_AXI_0_rvalid  = g_port[0].rvalid;
    assign S_AXI_0_rdata   = g_port[0].rdata;
    assign S_AXI_1_awready = g_port[1].awready;
    assign S_AXI_1_wready  = g_port[1].wready;
    assign S_AXI_1_bvalid  = g_port[1].bvalid;
    assign S_AXI_1_arready = g_port[1].arready;
    assign S_AXI_1_rvalid  = g_port[1].rvalid;
    assign S_AXI_1_rdata   = g_port[1].rdata;

endmodule

// File: tb/tb_memory_block_wrapper.sv
// Bench for memory_block_wrapper: directed scenarios then random single transactions,
// with read data predicted from a word-array model of the shared memory.
module tb_memory_block_wrapper;
  localparam int AW    = 12;
  localparam int DW    = 32;
  localparam int DEPTH = 1024;

  logic          sys_clock = 1'b0;
  logic          reset_rtl = 1'b1;
  logic [AW-1:0] awaddr [2];
  logic [AW-1:0] araddr [2];
  logic [DW-1:0] wdata [2];
  logic [1:0]    awvalid, wvalid, bready, arvalid, rready;
  wire  [1:0]    awready, wready, bvalid, arready, rvalid;
  wire  [DW-1:0] rdata [2];

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] model_mem [DEPTH];
  bit            known [DEPTH];
  int            known_list[$];
  logic [DW-1:0] exp_q[$];

  memory_block_wrapper #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .sys_clock       (sys_clock),
    .reset_rtl       (reset_rtl),
    .S_AXI_0_awaddr  (awaddr[0]),
    .S_AXI_0_awvalid (awvalid[0]),
    .S_AXI_0_awready (awready[0]),
    .S_AXI_0_wdata   (wdata[0]),
    .S_AXI_0_wvalid  (wvalid[0]),
    .S_AXI_0_wready  (wready[0]),
    .S_AXI_0_bvalid  (bvalid[0]),
    .S_AXI_0_bready  (bready[0]),
    .S_AXI_0_araddr  (araddr[0]),
    .S_AXI_0_arvalid (arvalid[0]),
    .S_AXI_0_arready (arready[0]),
    .S_AXI_0_rdata   (rdata[0]),
    .S_AXI_0_rvalid  (rvalid[0]),
    .S_AXI_0_rready  (rready[0]),
    .S_AXI_1_awaddr  (awaddr[1]),
    .S_AXI_1_awvalid (awvalid[1]),
    .S_AXI_1_awready (awready[1]),
    .S_AXI_1_wdata   (wdata[1]),
    .S_AXI_1_wvalid  (wvalid[1]),
    .S_AXI_1_wready  (wready[1]),
    .S_AXI_1_bvalid  (bvalid[1]),
    .S_AXI_1_bready  (bready[1]),
    .S_AXI_1_araddr  (araddr[1]),
    .S_AXI_1_arvalid (arvalid[1]),
    .S_AXI_1_arready (arready[1]),
    .S_AXI_1_rdata   (rdata[1]),
    .S_AXI_1_rvalid  (rvalid[1]),
    .S_AXI_1_rready  (rready[1])
  );

  // ---------------- clock / reset ----------------
  always #5 sys_clock = ~sys_clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_errors=%0d", n_errors);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge sys_clock);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    int idx;
    idx = int'(addr[AW-1:2]);
    model_mem[idx] = data;
    if (!known[idx]) begin
      known[idx] = 1'b1;
      known_list.push_back(idx);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic axi_write(input int p, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input int gap, input int bdelay);
    bit aw_done, w_done, aw_fire, w_fire;
    int cyc;
    awaddr[p]  = addr;
    wdata[p]   = data;
    awvalid[p] = 1'b1;
    wvalid[p]  = (gap == 0);
    aw_done = 0;
    w_done  = 0;
    cyc     = 0;
    while (!(aw_done && w_done) && cyc < 50) begin
      aw_fire = awvalid[p] && awready[p];
      w_fire  = wvalid[p] && wready[p];
      tick();
      if (aw_fire) begin awvalid[p] = 1'b0; aw_done = 1; end
      if (w_fire)  begin wvalid[p]  = 1'b0; w_done  = 1; end
      cyc++;
      if (!w_done && cyc >= gap) wvalid[p] = 1'b1;
    end
    awvalid[p] = 1'b0;
    wvalid[p]  = 1'b0;
    check("write_handshake_done", {31'd0, aw_done && w_done}, 32'd1);
    check("bvalid_after_commit", {31'd0, bvalid[p]}, 32'd1);
    model_write(addr, data);
    for (int i = 0; i < bdelay; i++) begin
      tick();
      check("bvalid_held", {31'd0, bvalid[p]}, 32'd1);
      check("awready_blocked", {31'd0, awready[p]}, 32'd0);
      check("wready_blocked", {31'd0, wready[p]}, 32'd0);
    end
    bready[p] = 1'b1;
    tick();
    bready[p] = 1'b0;
    check("bvalid_cleared", {31'd0, bvalid[p]}, 32'd0);
  endtask

  task automatic axi_read(input int p, input logic [AW-1:0] addr, input int rdelay);
    bit fire;
    int cyc;
    logic [DW-1:0] got;
    exp_q.push_back(model_mem[int'(addr[AW-1:2])]);
    araddr[p]  = addr;
    arvalid[p] = 1'b1;
    fire = 0;
    cyc  = 0;
    while (!fire && cyc < 50) begin
      fire = arready[p];
      tick();
      cyc++;
    end
    arvalid[p] = 1'b0;
    check("read_handshake_done", {31'd0, fire}, 32'd1);
    check("rvalid_latency", {31'd0, rvalid[p]}, 32'd1);
    got = rdata[p];
    for (int i = 0; i < rdelay; i++) begin
      tick();
      check("rvalid_held", {31'd0, rvalid[p]}, 32'd1);
      check("rdata_held", rdata[p], exp_q[$]);
    end
    rready[p] = 1'b1;
    tick();
    rready[p] = 1'b0;
    check("rvalid_cleared", {31'd0, rvalid[p]}, 32'd0);
    check("read_data", got, exp_q.pop_front());
  endtask

  task automatic dual_write(input logic [AW-1:0] addr, input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    awaddr[0] = addr;
    awaddr[1] = addr;
    wdata[0]  = d0;
    wdata[1]  = d1;
    awvalid   = 2'b11;
    wvalid    = 2'b11;
    tick();
    awvalid = 2'b00;
    wvalid  = 2'b00;
    check("dual_bvalid0", {31'd0, bvalid[0]}, 32'd1);
    check("dual_bvalid1", {31'd0, bvalid[1]}, 32'd1);
    model_write(addr, d0);
    bready = 2'b11;
    tick();
    bready = 2'b00;
    check("dual_bvalid_cleared", {30'd0, bvalid}, 32'd0);
  endtask

  // Port 0 writes while port 1 reads the same word on the same edge.
  task automatic collide_rw(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    logic [DW-1:0] old;
    old        = model_mem[int'(addr[AW-1:2])];
    awaddr[0]  = addr;
    wdata[0]   = data;
    araddr[1]  = addr;
    awvalid[0] = 1'b1;
    wvalid[0]  = 1'b1;
    arvalid[1] = 1'b1;
    tick();
    awvalid[0] = 1'b0;
    wvalid[0]  = 1'b0;
    arvalid[1] = 1'b0;
    check("coll_bvalid0", {31'd0, bvalid[0]}, 32'd1);
    check("coll_rvalid1", {31'd0, rvalid[1]}, 32'd1);
    check("coll_read_old", rdata[1], old);
    model_write(addr, data);
    bready[0] = 1'b1;
    rready[1] = 1'b1;
    tick();
    bready[0] = 1'b0;
    rready[1] = 1'b0;
  endtask

  // A held AW must be dropped by reset, so a later lone W cannot commit.
  task automatic reset_mid_write(input logic [AW-1:0] lost_addr, input logic [AW-1:0] new_addr,
                                 input logic [DW-1:0] data);
    awaddr[0]  = lost_addr;
    awvalid[0] = 1'b1;
    tick();
    awvalid[0] = 1'b0;
    reset_rtl  = 1'b1;
    tick();
    reset_rtl  = 1'b0;
    tick();
    wdata[0]  = data;
    wvalid[0] = 1'b1;
    tick();
    wvalid[0] = 1'b0;
    tick();
    check("reset_dropped_aw", {31'd0, bvalid[0]}, 32'd0);
    awaddr[0]  = new_addr;
    awvalid[0] = 1'b1;
    tick();
    awvalid[0] = 1'b0;
    check("held_w_commit", {31'd0, bvalid[0]}, 32'd1);
    model_write(new_addr, data);
    bready[0] = 1'b1;
    tick();
    bready[0] = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    awvalid = '0; wvalid = '0; bready = '0; arvalid = '0; rready = '0;
    for (int p = 0; p < 2; p++) begin
      awaddr[p] = '0;
      araddr[p] = '0;
      wdata[p]  = '0;
    end

    reset_rtl = 1'b1;
    repeat (10) tick();
    check("rst_awready", {30'd0, awready}, 32'd0);
    check("rst_wready", {30'd0, wready}, 32'd0);
    check("rst_arready", {30'd0, arready}, 32'd0);
    check("rst_bvalid", {30'd0, bvalid}, 32'd0);
    check("rst_rvalid", {30'd0, rvalid}, 32'd0);
    check("rst_rdata0", rdata[0], 32'd0);
    check("rst_rdata1", rdata[1], 32'd0);
    reset_rtl = 1'b0;
    tick();
    check("rel_awready", {30'd0, awready}, 32'd3);
    check("rel_wready", {30'd0, wready}, 32'd3);
    check("rel_arready", {30'd0, arready}, 32'd3);
    check("rel_bvalid", {30'd0, bvalid}, 32'd0);
    check("rel_rvalid", {30'd0, rvalid}, 32'd0);

    axi_write(0, 12'h100, 32'hDEADBEEF, 1, 0);
    axi_read(0, 12'h100, 0);
    axi_write(1, 12'h200, 32'hFACEFEED, 0, 0);
    axi_read(0, 12'h200, 1);
    dual_write(12'h040, 32'h11111111, 32'h22222222);
    axi_read(1, 12'h040, 0);
    axi_write(0, 12'h300, 32'h12345678, 0, 0);
    collide_rw(12'h300, 32'hA5A5A5A5);
    axi_read(1, 12'h300, 0);
    axi_write(1, 12'h104, 32'h0BADF00D, 0, 3);
    axi_read(0, 12'h107, 2);
    reset_mid_write(12'h100, 12'h044, 32'hC0FFEE01);
    axi_read(1, 12'h100, 0);
    axi_read(0, 12'h044, 0);

    for (int it = 0; it < 80; it++) begin
      int op;
      int p;
      logic [9:0] wi;
      logic [1:0] lo;
      op = int'($urandom_range(0, 9));
      p  = int'($urandom_range(0, 1));
      lo = 2'($urandom_range(0, 3));
      if (op <= 4) begin
        wi = 10'($urandom_range(0, 63));
        axi_write(p, {wi, lo}, $urandom, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
      end else if (op <= 8) begin
        wi = 10'(known_list[$urandom_range(0, known_list.size() - 1)]);
        axi_read(p, {wi, lo}, int'($urandom_range(0, 2)));
      end else begin
        wi = 10'($urandom_range(0, 63));
        dual_write({wi, lo}, $urandom, $urandom);
      end
    end

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
